// File: rtl/board_frame_streamer.sv
// Snapshots the game's visible state and streams it as an 86-byte frame over a
// valid/ready byte interface: header, 81 cells, 3 status bytes, XOR checksum.
module board_frame_streamer #(
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter bit         AUTO_REPEAT = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         frame_req,
    input  logic [404:0] board,
    input  logic [3:0]   pos_i,
    input  logic [3:0]   pos_j,
    input  logic         error,
    input  logic [6:0]   score,
    input  logic [10:0]  playtime,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy
);

    typedef enum logic [2:0] {IDLE, HDR, CELL, STAT, CSUM} state_t;

    state_t         state, state_nxt;
    logic           start;
    logic           accept;
    logic           pending;
    logic [6:0]     cnt;
    logic [7:0]     csum;

    logic [404:0]   snap_board;
    logic [3:0]     snap_pos_i;
    logic [3:0]     snap_pos_j;
    logic           snap_error;
    logic [6:0]     snap_score;
    logic [10:0]    snap_playtime;

    logic [8:0]     cell_base;
    logic [6:0]     cur_idx;
    logic           cur;

    assign accept    = out_valid && out_ready;
    assign cell_base = {2'b00, cnt} * 9'd5;
    assign cur_idx   = {3'b000, snap_pos_i} * 7'd9 + {3'b000, snap_pos_j};
    assign cur       = (cnt == cur_idx) && (snap_pos_i <= 4'd8) && (snap_pos_j <= 4'd8);

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (frame_req || pending || AUTO_REPEAT) begin
                    state_nxt = HDR;
                    start     = 1'b1;
                end
            end
            HDR:  if (accept) state_nxt = CELL;
            CELL: if (accept && cnt == 7'd80) state_nxt = STAT;
            STAT: if (accept && cnt == 7'd2) state_nxt = CSUM;
            CSUM: if (accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode straight from state, so they hold while stalled.
    always_comb begin
        out_valid = (state != IDLE);
        busy      = (state != IDLE);
        out_last  = (state == CSUM);
        out_data  = 8'h00;
        case (state)
            HDR:  out_data = HEADER;
            CELL: out_data = {cur, 2'b00, snap_board[cell_base +: 5]};
            STAT: begin
                case (cnt)
                    7'd0:    out_data = {snap_error, snap_score};
                    7'd1:    out_data = {5'b00000, snap_playtime[10:8]};
                    default: out_data = snap_playtime[7:0];
                endcase
            end
            CSUM: out_data = csum;
            default: out_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            pending <= 1'b0;
            cnt     <= 7'd0;
            csum    <= 8'h00;
        end else begin
            state <= state_nxt;
            if (start) begin
                pending <= 1'b0;
                cnt     <= 7'd0;
                csum    <= 8'h00;
            end else begin
                // Requests during a frame, including on the checksum beat, queue one frame.
                if (frame_req && state != IDLE)
                    pending <= 1'b1;
                if (accept) begin
                    csum <= csum ^ out_data;
                    cnt  <= (state_nxt != state) ? 7'd0 : cnt + 7'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            snap_board    <= board;
            snap_pos_i    <= pos_i;
            snap_pos_j    <= pos_j;
            snap_error    <= error;
            snap_score    <= score;
            snap_playtime <= playtime;
        end
    end

endmodule
